osd_video_mixer: RTL and testbench

//  Video-path companion of the OSD generator, clocked on vclk. Derives the

---
 rtl/osd_video_mixer.sv | 154 +++++++++++++++
 tb/tb_osd_video_mixer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_video_mixer.sv
// Video-side companion of the OSD generator: raster position tracking, video delay
// matched to the generator's return latency, and OSD colour overlay with optional blue blend.
module osd_video_mixer #(
  parameter int OSD_LATENCY = 7,
  parameter int X_W         = 12,
  parameter int Y_W         = 11
) (
  input  logic           vclk,
  input  logic           rst_n,
  input  logic [7:0]     R_i,
  input  logic [7:0]     G_i,
  input  logic [7:0]     B_i,
  input  logic           HSYNC_i,
  input  logic           VSYNC_i,
  input  logic           DE_i,
  input  logic [1:0]     osd_bg_alpha,
  output logic [X_W-1:0] xpos,
  output logic [Y_W-1:0] ypos,
  input  logic           osd_enable_i,
  input  logic [2:0]     osd_color_i,
  output logic [7:0]     R_o,
  output logic [7:0]     G_o,
  output logic [7:0]     B_o,
  output logic           HSYNC_o,
  output logic           VSYNC_o,
  output logic           DE_o
);

  localparam int PW = 27;

  logic [23:0]   rgb_p0;
  logic          hs_p0;
  logic          vs_p0;
  logic          vld_p0;
  logic [PW-1:0] dly_p1 [OSD_LATENCY+1];
  logic          frame_ok;
  logic [1:0]    alpha_l;
  logic          vld_prev;
  logic          vs_rise;
  logic          de_fall;
  logic [PW-1:0] tap;
  logic [23:0]   tap_rgb;
  logic          tap_vld;
  logic [23:0]   osd_c;
  logic          ovl;
  logic [23:0]   mix_rgb;

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (&v) ? v : v + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (&v) ? v : v + Y_W'(1);
  endfunction

  // Weights sum to 4, so the 10-bit sum tops out at 1020 and the >>2 result fits 8 bits.
  function automatic logic [7:0] blend_ch(input logic [7:0] osd, input logic [7:0] vid,
                                          input logic [1:0] a);
    logic [9:0] w_osd;
    logic [9:0] w_vid;
    logic [9:0] acc;
    w_osd = 10'(3'd4 - {1'b0, a});
    w_vid = 10'(a);
    acc   = 10'(osd) * w_osd + 10'(vid) * w_vid;
    return acc[9:2];
  endfunction

  // Stage p0: input capture
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_p0 <= '0;
      hs_p0  <= 1'b0;
      vs_p0  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      rgb_p0 <= {R_i, G_i, B_i};
      hs_p0  <= HSYNC_i;
      vs_p0  <= VSYNC_i;
      vld_p0 <= DE_i;
    end
  end

  // Stage 0 of the delay line runs alongside xpos, so it doubles as the previous-sample copy.
  assign vld_prev = dly_p1[0][0];
  assign vs_rise  = vs_p0 & ~dly_p1[0][1];
  assign de_fall  = ~vld_p0 & vld_prev;

  // Stage p1..p(OSD_LATENCY+1): delay line
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= OSD_LATENCY; i++) dly_p1[i] <= '0;
    end else begin
      dly_p1[0] <= {rgb_p0, hs_p0, vs_p0, vld_p0};
      for (int i = 1; i <= OSD_LATENCY; i++) dly_p1[i] <= dly_p1[i-1];
    end
  end

  // First pixel of a line keeps the zero left by de_fall/vs_rise so positions name the current pixel.
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      xpos     <= '0;
      ypos     <= '0;
      frame_ok <= 1'b0;
      alpha_l  <= 2'd0;
    end else if (vs_rise) begin
      xpos     <= '0;
      ypos     <= '0;
      frame_ok <= 1'b1;
      alpha_l  <= osd_bg_alpha;
    end else if (de_fall) begin
      xpos <= '0;
      ypos <= sat_inc_y(ypos);
    end else if (vld_p0) begin
      xpos <= vld_prev ? sat_inc_x(xpos) : '0;
    end
  end

  assign tap     = dly_p1[OSD_LATENCY];
  assign tap_rgb = tap[26:3];
  assign tap_vld = tap[0];
  assign osd_c   = {{8{osd_color_i[2]}}, {8{osd_color_i[1]}}, {8{osd_color_i[0]}}};
  assign ovl     = osd_enable_i & frame_ok & tap_vld;

  always_comb begin
    mix_rgb = '0;
    if (tap_vld) begin
      if (!ovl) begin
        mix_rgb = tap_rgb;
      end else if (osd_color_i != 3'h1 || alpha_l == 2'd0) begin
        mix_rgb = osd_c;
      end else begin
        mix_rgb = {blend_ch(osd_c[23:16], tap_rgb[23:16], alpha_l),
                   blend_ch(osd_c[15:8],  tap_rgb[15:8],  alpha_l),
                   blend_ch(osd_c[7:0],   tap_rgb[7:0],   alpha_l)};
      end
    end
  end

  // Stage mix: output registers
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      {R_o, G_o, B_o} <= '0;
      HSYNC_o         <= 1'b0;
      VSYNC_o         <= 1'b0;
      DE_o            <= 1'b0;
    end else begin
      {R_o, G_o, B_o} <= mix_rgb;
      HSYNC_o         <= tap[2];
      VSYNC_o         <= tap[1];
      DE_o            <= tap_vld;
    end
  end

endmodule

// File: tb/tb_osd_video_mixer.sv
// Bench for osd_video_mixer: randomized and directed pixel streams against a per-pixel reference model.
module tb_osd_video_mixer;

  localparam int N = 20000;

  logic        vclk;
  logic        rst_n;
  logic [7:0]  R_i, G_i, B_i;
  logic        HSYNC_i, VSYNC_i, DE_i;
  logic [1:0]  osd_bg_alpha;
  logic [11:0] xpos;
  logic [10:0] ypos;
  logic        osd_enable_i;
  logic [2:0]  osd_color_i;
  logic [7:0]  R_o, G_o, B_o;
  logic        HSYNC_o, VSYNC_o, DE_o;

  osd_video_mixer dut (
    .vclk(vclk), .rst_n(rst_n),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .osd_bg_alpha(osd_bg_alpha),
    .xpos(xpos), .ypos(ypos),
    .osd_enable_i(osd_enable_i), .osd_color_i(osd_color_i),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o)
  );

  initial vclk = 1'b0;
  always #5 vclk = ~vclk;

  // Per-pixel record of what was driven, plus model state snapshot after that pixel.
  logic [7:0] r_a [N];
  logic [7:0] g_a [N];
  logic [7:0] b_a [N];
  logic       hs_a [N];
  logic       vs_a [N];
  logic       de_a [N];
  logic       oen_a [N];
  logic [2:0] oc_a [N];
  int         xs_a [N];
  int         ys_a [N];
  logic       fok_a [N];
  logic [1:0] al_a [N];

  int         n;
  int         checks;
  int         failures;
  logic       m_pvs, m_pde, m_fok;
  int         m_x, m_y;
  logic [1:0] m_al;

  task automatic model_clear();
    m_pvs = 0; m_pde = 0; m_fok = 0; m_x = 0; m_y = 0; m_al = 0;
  endtask

  // One pixel per clock: inputs change at the falling edge, osd return is the pixel 9 steps back.
  task automatic drive_step(input logic de, input logic hs, input logic vs,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic oen, input logic [2:0] oc);
    logic vr, df;
    if (n >= N) begin
      $display("FAIL step_budget n=%0d limit=%0d", n, N);
      $fatal(1);
    end
    @(negedge vclk);
    DE_i = de; HSYNC_i = hs; VSYNC_i = vs; R_i = r; G_i = g; B_i = b;
    osd_enable_i = (n >= 9) ? oen_a[n-9] : 1'b0;
    osd_color_i  = (n >= 9) ? oc_a[n-9]  : 3'd0;
    oen_a[n] = oen; oc_a[n] = oc;
    if (!rst_n) begin
      de_a[n] = 0; hs_a[n] = 0; vs_a[n] = 0; r_a[n] = 0; g_a[n] = 0; b_a[n] = 0;
      model_clear();
    end else begin
      de_a[n] = de; hs_a[n] = hs; vs_a[n] = vs; r_a[n] = r; g_a[n] = g; b_a[n] = b;
      vr = vs & ~m_pvs;
      df = ~de & m_pde;
      if (vr) begin
        m_x = 0; m_y = 0; m_fok = 1; m_al = osd_bg_alpha;
      end else if (df) begin
        m_x = 0;
        if (m_y < 2047) m_y++;
      end else if (de) begin
        if (!m_pde) m_x = 0;
        else if (m_x < 4095) m_x++;
      end
      m_pvs = vs; m_pde = de;
    end
    xs_a[n] = m_x; ys_a[n] = m_y; fok_a[n] = m_fok; al_a[n] = m_al;
    n++;
  endtask

  // Expected {R,G,B,HS,VS,DE} for pixel t; frame state is the one in force when t reaches the mixer.
  function automatic logic [26:0] exp_out(input int t);
    logic [23:0] vid;
    logic [2:0]  c;
    int          a, rr, gg, bb;
    vid = {r_a[t], g_a[t], b_a[t]};
    c   = oc_a[t];
    if (!de_a[t]) return {24'h0, hs_a[t], vs_a[t], 1'b0};
    if (!(oen_a[t] && fok_a[t+7])) return {vid, hs_a[t], vs_a[t], 1'b1};
    a = int'(al_a[t+7]);
    if (c != 3'd1 || a == 0)
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}, hs_a[t], vs_a[t], 1'b1};
    rr = (int'(r_a[t]) * a) / 4;
    gg = (int'(g_a[t]) * a) / 4;
    bb = (255 * (4 - a) + int'(b_a[t]) * a) / 4;
    return {8'(rr), 8'(gg), 8'(bb), hs_a[t], vs_a[t], 1'b1};
  endfunction

  task automatic assert_rst();
    #2 rst_n = 1'b0;
    for (int i = n - 10; i < n; i++) begin
      if (i >= 0) begin
        de_a[i] = 0; hs_a[i] = 0; vs_a[i] = 0; r_a[i] = 0; g_a[i] = 0; b_a[i] = 0;
      end
    end
    model_clear();
  endtask

  task automatic release_rst();
    @(posedge vclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic vsync_pulse();
    drive_step(0, 0, 1, 0, 0, 0, 0, 0);
    drive_step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive_step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int p0;
    for (int i = 0; i < 3; i++) drive_step(1, 1, 1, 8'hAA, 8'h55, 8'hCC, 1, 3'd7);
    checks++;
    if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos, ypos} !== 50'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", {R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos, ypos});
    end
    release_rst();
    vsync_pulse();
    for (int i = 0; i < 30; i++)
      drive_step(1, 0, 0, 8'($urandom), 8'($urandom), 8'h01, 0, 3'd0);
    assert_rst();
    #1;
    checks++;
    if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos, ypos} !== 50'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", {R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o, xpos, ypos});
    end
    drive_step(1, 0, 0, 8'h11, 8'h22, 8'h33, 0, 0);
    drive_step(1, 0, 0, 8'h11, 8'h22, 8'h33, 0, 0);
    release_rst();
    p0 = n;
    for (int i = 0; i < 14; i++) begin
      drive_step(1, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 1, 3'd7);
      checks++;
      if (DE_o !== ((n - 1 - p0) >= 10)) begin
        failures++;
        $display("FAIL reset_release_de step=%0d got=%b exp=%b", i, DE_o, ((n - 1 - p0) >= 10));
      end
      checks++;
      if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o} !== exp_out(n - 11)) begin
        failures++;
        $display("FAIL reset_release_out t=%0d got=%h exp=%h", n - 11,
                 {R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o}, exp_out(n - 11));
      end
    end
    drive_step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_latency();
    int k;
    vsync_pulse();
    for (int i = 0; i < 12; i++) drive_step(0, 0, 0, 0, 0, 0, 0, 0);
    k = n;
    drive_step(1, 0, 0, 8'h12, 8'h34, 8'h56, 0, 3'd0);
    for (int i = 0; i < 14; i++) begin
      drive_step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (DE_o !== (n - 11 == k)) begin
        failures++;
        $display("FAIL latency_de t=%0d got=%b exp=%b", n - 11, DE_o, (n - 11 == k));
      end
      if (n - 11 == k) begin
        checks++;
        if ({R_o, G_o, B_o} !== 24'h123456) begin
          failures++;
          $display("FAIL latency_rgb got=%h exp=123456", {R_o, G_o, B_o});
        end
      end
    end
  endtask

  task automatic test_counters();
    int p;
    osd_bg_alpha = 2'($urandom);
    vsync_pulse();
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < ((f == 0) ? 3 : 1); l++) begin
        for (int i = 0; i < ((f == 0) ? 660 : 40); i++) begin
          drive_step((i < 640) && (f == 0 || i < 16), (i >= 645 && i < 650), 0,
                     8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom), 3'($urandom));
          p = n - 3;
          if (de_a[p]) begin
            checks++;
            if (xpos !== 12'(xs_a[p]) || ypos !== 11'(ys_a[p])) begin
              failures++;
              $display("FAIL counters_pos t=%0d got=%0d,%0d exp=%0d,%0d",
                       p, xpos, ypos, xs_a[p], ys_a[p]);
            end
          end
          checks++;
          if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o} !== exp_out(n - 11)) begin
            failures++;
            $display("FAIL counters_out t=%0d got=%h exp=%h", n - 11,
                     {R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o}, exp_out(n - 11));
          end
        end
      end
      if (f == 0) begin
        checks++;
        if (ypos !== 11'd3 || xpos !== 12'd0) begin
          failures++;
          $display("FAIL counters_frame_end got=%0d,%0d exp=0,3", xpos, ypos);
        end
        osd_bg_alpha = 2'($urandom);
        vsync_pulse();
      end
    end
    checks++;
    if (ypos !== 11'd1) begin
      failures++;
      $display("FAIL counters_second_frame ypos got=%0d exp=1", ypos);
    end
  endtask

  task automatic test_opaque();
    int k0;
    logic [23:0] tab [4];
    logic [2:0]  col [4];
    tab[0] = 24'hFFFFFF; tab[1] = 24'hFFFF00; tab[2] = 24'h40207F; tab[3] = 24'h000000;
    col[0] = 3'd7; col[1] = 3'd6; col[2] = 3'd1; col[3] = 3'd0;
    osd_bg_alpha = 2'd2;
    vsync_pulse();
    k0 = n;
    for (int i = 0; i < 4; i++) drive_step(1, 0, 0, 8'h80, 8'h40, 8'h00, 1, col[i]);
    for (int i = 0; i < 16; i++) begin
      drive_step(0, 0, 0, 0, 0, 0, 0, 0);
      if (n - 11 >= k0 && n - 11 < k0 + 4) begin
        checks++;
        if ({R_o, G_o, B_o} !== tab[n - 11 - k0]) begin
          failures++;
          $display("FAIL opaque_color c=%0d got=%h exp=%h", col[n - 11 - k0],
                   {R_o, G_o, B_o}, tab[n - 11 - k0]);
        end
      end
    end
  endtask

  task automatic test_blend();
    int k0;
    logic [23:0] want;
    osd_bg_alpha = 2'd2;
    vsync_pulse();
    k0 = n;
    for (int i = 0; i < 60; i++) begin
      if (i == 30) osd_bg_alpha = 2'd0;
      drive_step(i < 40, 0, 0, 8'h80, 8'h40, 8'h00, 1, 3'd1);
      if (n - 11 >= k0 && n - 11 < k0 + 40) begin
        checks++;
        if ({R_o, G_o, B_o} !== 24'h40207F) begin
          failures++;
          $display("FAIL blend_a2 t=%0d got=%h exp=40207F", n - 11, {R_o, G_o, B_o});
        end
      end
    end
    vsync_pulse();
    k0 = n;
    for (int i = 0; i < 20; i++) begin
      drive_step(i < 5, 0, 0, 8'h80, 8'h40, 8'h00, 1, 3'd1);
      want = 24'h0000FF;
      if (n - 11 >= k0 && n - 11 < k0 + 5) begin
        checks++;
        if ({R_o, G_o, B_o} !== want) begin
          failures++;
          $display("FAIL blend_a0_next_frame got=%h exp=%h", {R_o, G_o, B_o}, want);
        end
      end
    end
  endtask

  task automatic test_edge_cases();
    int ls, p, exp_x;
    logic [23:0] vid;
    vsync_pulse();
    ls = n;
    for (int i = 0; i < 5010; i++) begin
      drive_step(i < 5000, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
      p = n - 3;
      if (p >= ls && p < ls + 5000) begin
        exp_x = (p - ls > 4095) ? 4095 : p - ls;
        if (p - ls >= 4090) begin
          checks++;
          if (xpos !== 12'(exp_x)) begin
            failures++;
            $display("FAIL edge_xpos_sat i=%0d got=%0d exp=%0d", p - ls, xpos, exp_x);
          end
        end
      end
      if (i % 97 == 0) begin
        checks++;
        if ({R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o} !== exp_out(n - 11)) begin
          failures++;
          $display("FAIL edge_long_out t=%0d got=%h exp=%h", n - 11,
                   {R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o}, exp_out(n - 11));
        end
      end
    end
    vsync_pulse();
    for (int l = 0; l < 2050; l++) begin
      drive_step(1, 0, 0, 8'h10, 8'h20, 8'h30, 0, 0);
      drive_step(0, 0, 0, 0, 0, 0, 0, 0);
      if (l == 2046 || l == 2049) begin
        checks++;
        if (ypos !== 11'(((l > 2047) ? 2047 : l))) begin
          failures++;
          $display("FAIL edge_ypos_sat line=%0d got=%0d exp=%0d", l, ypos, ((l > 2047) ? 2047 : l));
        end
      end
    end
    checks++;
    if (ypos !== 11'd2047) begin
      failures++;
      $display("FAIL edge_ypos_final got=%0d exp=2047", ypos);
    end
    assert_rst();
    drive_step(0, 0, 0, 0, 0, 0, 0, 0);
    release_rst();
    ls = n;
    for (int i = 0; i < 30; i++) begin
      drive_step(i < 20, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom), 1, 3'd7);
      if (n - 11 >= ls && n - 11 < ls + 20) begin
        vid = {r_a[n - 11], g_a[n - 11], b_a[n - 11]};
        checks++;
        if ({R_o, G_o, B_o} !== vid || DE_o !== 1'b1) begin
          failures++;
          $display("FAIL edge_pre_vsync t=%0d got=%h exp=%h", n - 11, {R_o, G_o, B_o}, vid);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog n=%0d limit=%0d", n, N);
    $fatal(1);
  end

  initial begin
    n = 0; checks = 0; failures = 0;
    rst_n = 1'b0;
    R_i = 0; G_i = 0; B_i = 0; HSYNC_i = 0; VSYNC_i = 0; DE_i = 0;
    osd_bg_alpha = 2'd0; osd_enable_i = 0; osd_color_i = 0;
    model_clear();
    test_reset();
    test_latency();
    test_counters();
    test_opaque();
    test_blend();
    test_edge_cases();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
